// File: rtl/scan_pkg.sv
// Shared definitions for the ultrasonic scan controller: FSM state encoding,
// timer width and default timing constants (all times in 1 MHz clock cycles).
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_SETTLE,
        ST_CAPTURE,
        ST_CLEAR,
        ST_GAP
    } scan_state_t;

    localparam int TIMER_W            = 16;
    localparam int DIST_W             = 20;

    localparam int DEF_N_SENSORS      = 4;
    localparam int DEF_TRIG_US        = 10;
    localparam int DEF_TIMEOUT_US     = 30000;
    localparam int DEF_SETTLE_US      = 4;
    localparam int DEF_PERIOD_US      = 60000;

endpackage

// File: rtl/scan_slot_timer.sv
// 16-bit saturating up-counter with synchronous clear and a ">= limit" flag.
// Used both as the slot timer and as the echo timeout / settle timer.
module scan_slot_timer
    import scan_pkg::*;
(
    input  logic               clk_1m,
    input  logic               rst,
    input  logic               i_clr,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_reached
);

    logic [TIMER_W-1:0] r_count;

    // Count every cycle, restart from zero on clear, stick at all-ones instead of wrapping
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_reached = (r_count >= i_limit);

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin scheduler sharing one echo pulse-width counter between up to
// four ultrasonic rangers: trigger, route echo, capture distance or time out.
module ultrasonic_scan_ctrl
    import scan_pkg::*;
#(
    parameter int N_SENSORS  = DEF_N_SENSORS,
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int SETTLE_US  = DEF_SETTLE_US,
    parameter int PERIOD_US  = DEF_PERIOD_US
) (
    input  logic                 clk_1m,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_SENSORS-1:0] echo_in,
    output logic [N_SENSORS-1:0] trig_out,
    output logic                 echo_mux,
    output logic                 cnt_rst_n,
    input  logic [DIST_W-1:0]    dis_count,
    output logic [1:0]           sel,
    output logic [DIST_W-1:0]    result,
    output logic [1:0]           result_id,
    output logic                 result_valid,
    output logic                 result_timeout,
    output logic                 busy
);

    localparam logic [1:0]           LAST_SEL = 2'(N_SENSORS - 1);
    localparam logic [N_SENSORS-1:0] ONE_HOT0 = N_SENSORS'(1);

    scan_state_t         r_state;
    scan_state_t         w_next;
    logic [1:0]          r_sel;
    logic [1:0]          w_selNew;
    logic                w_selAdv;
    logic [N_SENSORS-1:0] r_trig;
    logic [1:0]          r_sync;
    logic                r_echoD;
    logic                r_clr;
    logic [DIST_W-1:0]   r_result;
    logic [1:0]          r_resultId;
    logic                r_valid;
    logic                r_timeout;

    logic                w_echoS;
    logic                w_rise;
    logic                w_fall;
    logic                w_slotClr;
    logic                w_toClr;
    logic [TIMER_W-1:0]  w_slotLimit;
    logic [TIMER_W-1:0]  w_toLimit;
    logic                w_slotReached;
    logic                w_toReached;

    assign echo_mux = echo_in[r_sel];
    assign w_echoS  = r_sync[1];
    assign w_rise   = w_echoS & ~r_echoD;
    assign w_fall   = ~w_echoS & r_echoD;
    assign w_selNew = w_selAdv ? ((r_sel == LAST_SEL) ? 2'd0 : r_sel + 2'd1) : r_sel;

    scan_slot_timer u_slotTimer (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .i_clr     (w_slotClr),
        .i_limit   (w_slotLimit),
        .o_reached (w_slotReached)
    );

    scan_slot_timer u_timeoutTimer (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .i_clr     (w_toClr),
        .i_limit   (w_toLimit),
        .o_reached (w_toReached)
    );

    // State register
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic, timer clears/limits and sensor advance; echo events win over a same-cycle timeout
    always_comb begin
        w_next      = r_state;
        w_slotClr   = 1'b0;
        w_toClr     = 1'b0;
        w_selAdv    = 1'b0;
        w_slotLimit = TIMER_W'(PERIOD_US - 1);
        w_toLimit   = TIMER_W'(TIMEOUT_US);
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next    = ST_TRIG;
                    w_slotClr = 1'b1;
                end
            end
            ST_TRIG: begin
                w_slotLimit = TIMER_W'(TRIG_US - 1);
                if (w_slotReached) begin
                    w_next  = ST_WAIT_RISE;
                    w_toClr = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (w_rise) begin
                    w_next = ST_WAIT_FALL;
                end else if (w_toReached) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_WAIT_FALL: begin
                if (w_fall) begin
                    w_next  = ST_SETTLE;
                    w_toClr = 1'b1;
                end else if (w_toReached) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_SETTLE: begin
                w_toLimit = TIMER_W'(SETTLE_US - 1);
                if (w_toReached) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_next = ST_GAP;
            ST_CLEAR:   w_next = ST_GAP;
            ST_GAP: begin
                if (w_slotReached) begin
                    w_selAdv = 1'b1;
                    if (en) begin
                        w_next    = ST_TRIG;
                        w_slotClr = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Echo synchronizer, edge history, trigger pins, counter clear strobe and result registers
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            r_sync     <= '0;
            r_echoD    <= 1'b0;
            r_sel      <= '0;
            r_trig     <= '0;
            r_clr      <= 1'b0;
            r_result   <= '0;
            r_resultId <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], echo_mux};
            r_echoD <= r_sync[1];
            r_sel   <= w_selNew;
            r_trig  <= (w_next == ST_TRIG) ? (ONE_HOT0 << w_selNew) : '0;
            r_clr   <= (w_next == ST_CLEAR);
            r_valid <= 1'b0;
            if (r_state == ST_CAPTURE) begin
                r_result   <= dis_count;
                r_resultId <= r_sel;
                r_valid    <= 1'b1;
                r_timeout  <= 1'b0;
            end else if (r_state == ST_CLEAR) begin
                r_result   <= '0;
                r_resultId <= r_sel;
                r_valid    <= 1'b1;
                r_timeout  <= 1'b1;
            end
        end
    end

    assign trig_out       = r_trig;
    assign sel            = r_sel;
    assign result         = r_result;
    assign result_id      = r_resultId;
    assign result_valid   = r_valid;
    assign result_timeout = r_timeout;
    assign busy           = (r_state != ST_IDLE);
    assign cnt_rst_n      = rst & ~r_clr;

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
Round-robin scheduler that shares one echo pulse-width counter between up to 4 ultrasonic rangers. Per slot it:
- selects a sensor and fires its trigger pulse;
- routes that sensor's echo to the shared counter;
- waits for the measurement, captures the counter's scaled distance output, or flags a timeout and clears the counter.

Sits between the sensor pins and the pulse counter; the result stream feeds the display/logic downstream.

Parameters:
N_SENSORS, 4, sensors scanned (1..4); sel wraps at N_SENSORS-1
TRIG_US, 10, trigger high time in clk_1m cycles
TIMEOUT_US, 30000, max cycles from trigger fall to echo fall
SETTLE_US, 4, cycles from synced echo fall to capture of dis_count
PERIOD_US, 60000, minimum cycles between successive trigger rising edges (16-bit slot timer)

Ports:
clk_1m  in  1  1 MHz clock
rst  in  1  reset, asynchronous, active-low
en  in  1  scan enable, level
echo_in  in  N_SENSORS  raw echo pins
trig_out  out  N_SENSORS  trigger pins, registered, one-hot or zero
echo_mux  out  1  echo_in[sel], combinational, to counter echo
cnt_rst_n  out  1  to counter rst: rst AND NOT clr_q
dis_count  in  20  counter distance output
sel  out  2  sensor currently owning the counter
result  out  20  captured distance, held until next capture
result_id  out  2  sensor index of result
result_valid  out  1  one-cycle pulse on capture
result_timeout  out  1  qualifies result_valid; 1 = no valid echo, result=0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; trig_out forced 0 asynchronously; state IDLE; sel 0; timers 0.
- Own 2-flop synchronizer on echo_in[sel] gives echo_s; all decisions use echo_s only.
- FSM states and transitions:
  - IDLE: if en, go to TRIG and clear slot timer.
  - TRIG: trig_out[sel]=1 for exactly TRIG_US cycles, then go to WAIT_RISE with timeout timer = 0.
  - WAIT_RISE: echo_s rising goes to WAIT_FALL.
  - WAIT_FALL: echo_s falling goes to SETTLE.
  - Timeout (WAIT_RISE or WAIT_FALL, timer reaches TIMEOUT_US): go to CLEAR.
  - SETTLE: wait SETTLE_US cycles, then go to CAPTURE.
  - CAPTURE (1 cycle): result<=dis_count, result_id<=sel, result_valid=1, result_timeout=0; go to GAP.
  - CLEAR (1 cycle): clr_q=1, so cnt_rst_n is low for 1 cycle; result<=0, result_id<=sel, result_valid=1, result_timeout=1; go to GAP.
  - GAP: wait until slot timer ≥ PERIOD_US-1. Then sel <= (sel==N_SENSORS-1)?0:sel+1. Then go to TRIG if en, else IDLE.
- Slot timer starts at TRIG entry and saturates, never wraps.
- Timeout timer saturates.
- sel changes only on the GAP exit edge, never while echo is being measured.
- Echo already high at TRIG entry (stale): ignored; WAIT_RISE needs a low-to-high transition, otherwise timeout.
- en deassert mid-slot: the current slot completes, including the result pulse; stops in IDLE after GAP. en reassert in IDLE: TRIG next cycle.
- echo_in of unselected sensors is ignored.
- Reset mid-slot: immediate return to reset values; no result pulse.
- N_SENSORS=1: sel stays 0.
- Worst-case slot length is PERIOD_US, or TRIG_US+TIMEOUT_US+3 if larger; GAP handles both.

Decomposition:
- Package scan_pkg: state encoding (IDLE, TRIG, WAIT_RISE, WAIT_FALL, SETTLE, CAPTURE, CLEAR, GAP) and default timing constants.
- One sub-module, scan_slot_timer: 16-bit saturating counter with clear and ≥ compare, instanced twice (slot and timeout).
- Shared pulse counter instanced at top level, not inside this block.

Test Plan:
1. en=1, sensor 0 echo rises 500 cycles after trigger fall, width 1000, counter attached → trig_out[0] high exactly 10 cycles; result_valid once, result within 1700±4, result_id=0, result_timeout=0.
2. Four sensors with echo widths 100/200/300/400 → results in order id 0,1,2,3,0; values ≈170/340/510/680; trigger rising edges exactly 60000 cycles apart.
3. Sensor 1 never echoes → result_valid 30001–30003 cycles after trigger fall, result_timeout=1, result=0; cnt_rst_n low 1 cycle; next sensor proceeds normally.
4. Echo held high beyond 30000 cycles → timeout pulse, counter cleared, dis_count returns 0; sel advances.
5. en dropped during WAIT_FALL of sensor 2 → result for id 2 still delivered, then IDLE with busy=0, no further triggers; sel=3.
6. rst asserted mid-TRIG → trig_out 0 asynchronously, all outputs 0; after release with en=1, scan restarts at sensor 0.
